// File: rtl/vx_sfu_lane_packetizer.sv
// vx_sfu_lane_packetizer: splits a warp SFU request into lane-group packets, skipping empty groups
module vx_sfu_lane_packetizer #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int DATAW       = 32,
  parameter int META_W      = 64,
  localparam int BATCH      = NUM_THREADS / NUM_LANES,
  localparam int PID_W      = BATCH > 1 ? $clog2(BATCH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic [NUM_THREADS*DATAW-1:0] in_data,
  input  logic [META_W-1:0]            in_meta,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_LANES-1:0]         out_tmask,
  output logic [NUM_LANES*DATAW-1:0]   out_data,
  output logic [META_W-1:0]            out_meta,
  output logic [PID_W-1:0]             out_pid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic                         busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                       state_q, state_d;
  logic [NUM_THREADS-1:0]       tmask_q, tmask_d;
  logic [NUM_THREADS*DATAW-1:0] data_q, data_d;
  logic [META_W-1:0]            meta_q, meta_d;
  logic [PID_W-1:0]             pid_q, pid_d, pid_in, pid_nx;
  logic                         sop_q, sop_d, eop_q, eop_d;
  logic [BATCH-1:0]             grp_in, grp_q;
  logic                         in_fire, out_fire, last_fire;
  function automatic logic [PID_W-1:0] lowest(input logic [BATCH-1:0] m);
    lowest = '0;
    for (int i = BATCH - 1; i >= 0; i--) if (m[i]) lowest = PID_W'(i);
  endfunction
  function automatic logic [BATCH-1:0] above(input logic [BATCH-1:0] m, input logic [PID_W-1:0] p);
    above = '0;
    for (int i = 0; i < BATCH; i++) above[i] = m[i] && (i > int'(p));
  endfunction
  for (genvar g = 0; g < BATCH; g++) begin : g_grp
    assign grp_in[g] = |in_tmask[g*NUM_LANES +: NUM_LANES];
    assign grp_q[g]  = |tmask_q[g*NUM_LANES +: NUM_LANES];
  end
  assign out_fire  = state_q == SEND && out_ready;
  assign last_fire = out_fire && eop_q;
  assign in_ready  = state_q == IDLE || last_fire;
  assign in_fire   = in_valid && in_ready;
  always_comb begin
    pid_in  = lowest(grp_in);
    pid_nx  = lowest(above(grp_q, pid_q));
    state_d = in_fire ? SEND : last_fire ? IDLE : state_q;
    tmask_d = in_fire ? in_tmask : tmask_q;
    data_d  = in_fire ? in_data : data_q;
    meta_d  = in_fire ? in_meta : meta_q;
    pid_d   = in_fire ? pid_in : out_fire ? pid_nx : pid_q;
    sop_d   = in_fire || (sop_q && !out_fire);
    eop_d   = in_fire ? ~|above(grp_in, pid_in) : out_fire ? ~|above(grp_q, pid_nx) : eop_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmask_q <= '0;
      data_q  <= '0;
      meta_q  <= '0;
      pid_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmask_q <= tmask_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end
  assign out_valid = state_q == SEND;
  assign busy      = state_q == SEND;
  assign out_tmask = tmask_q[int'(pid_q)*NUM_LANES +: NUM_LANES];
  assign out_data  = data_q[int'(pid_q)*NUM_LANES*DATAW +: NUM_LANES*DATAW];
  assign out_meta  = meta_q;
  assign out_pid   = pid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
endmodule

// File: tb/tb_vx_sfu_lane_packetizer.sv
// tb_vx_sfu_lane_packetizer: scoreboard bench with a per-warp packet model and random traffic
module tb_vx_sfu_lane_packetizer;
  localparam int NT = 4, NL = 2, DW = 32, MW = 64, B = NT / NL;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_sop, out_eop, busy;
  logic [NT-1:0] in_tmask = '0;
  logic [NT*DW-1:0] in_data = '0;
  logic [MW-1:0] in_meta = '0;
  logic [NL-1:0] out_tmask;
  logic [NL*DW-1:0] out_data;
  logic [MW-1:0] out_meta;
  logic [0:0] out_pid;
  typedef struct packed {
    logic [0:0] pid;
    logic [NL-1:0] tm;
    logic [NL*DW-1:0] d;
    logic [MW-1:0] m;
    logic sop;
    logic eop;
  } pkt_t;
  pkt_t q[$];
  pkt_t mon_c, mon_e, prev;
  int total = 0, bad = 0, cyc = 0, acc_cnt = 0, seen_acc = 0;
  bit rand_rdy = 0, prev_stall = 0;
  vx_sfu_lane_packetizer #(.NUM_THREADS(NT), .NUM_LANES(NL), .DATAW(DW), .META_W(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
    .in_data(in_data), .in_meta(in_meta), .out_valid(out_valid), .out_ready(out_ready),
    .out_tmask(out_tmask), .out_data(out_data), .out_meta(out_meta), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic pkt_t cur();
    pkt_t p;
    p.pid = out_pid;
    p.tm = out_tmask;
    p.d = out_data;
    p.m = out_meta;
    p.sop = out_sop;
    p.eop = out_eop;
    return p;
  endfunction
  task automatic model(input logic [NT-1:0] tm, input logic [NT*DW-1:0] d, input logic [MW-1:0] m);
    pkt_t l[$];
    pkt_t p;
    p = '0;
    p.m = m;
    for (int g = 0; g < B; g++)
      if (tm[g*NL +: NL] != 0) begin
        p.pid = 1'(g);
        p.tm = tm[g*NL +: NL];
        p.d = d[g*NL*DW +: NL*DW];
        l.push_back(p);
      end
    if (l.size() == 0) begin
      p.pid = 0;
      p.tm = 0;
      p.d = d[NL*DW-1:0];
      l.push_back(p);
    end
    for (int i = 0; i < l.size(); i++) begin
      p = l[i];
      p.sop = (i == 0);
      p.eop = (i == l.size() - 1);
      q.push_back(p);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      mon_c = cur();
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, q.size() == 0 || (out_valid && out_ready && q.size() != 0 && q[0].eop));
      chk("out_valid", out_valid, q.size() != 0);
      if (acc_cnt != seen_acc) begin
        chk("first_pkt_latency", {out_valid, out_sop}, 2'b11);
        seen_acc = acc_cnt;
      end
      if (prev_stall) chk("hold", mon_c, prev);
      prev_stall = out_valid && !out_ready;
      prev = mon_c;
      if (out_valid && out_ready && q.size() != 0) begin
        mon_e = q.pop_front();
        chk("pkt", mon_c, mon_e);
      end
    end else begin
      prev_stall = 0;
      seen_acc = acc_cnt;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic send(input logic [NT-1:0] tm, input logic [NT*DW-1:0] d, input logic [MW-1:0] m,
                      input bit keep, output int acc_cyc);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    acc_cyc = -1;
    in_valid = 1;
    in_tmask = tm;
    in_data = d;
    in_meta = m;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    if (ok) begin
      model(tm, d, m);
      acc_cnt++;
      acc_cyc = cyc;
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end
    if (!keep) in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
    tick();
  endtask
  initial begin
    #800000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    int c1, c2;
    logic [NT*DW-1:0] d;
    logic [MW-1:0] m;
    logic [NT-1:0] tm;
    bit keep;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_pid", out_pid, 0);
    chk("rst_out_tmask", out_tmask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_meta", out_meta, 0);
    reset = 1;
    tick();
    out_ready = 1;
    send(4'b1111, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 64'h1111_2222_3333_4444, 0, c1);
    drain();
    send(4'b1100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 64'hAAAA_0000_0000_0002, 0, c1);
    drain();
    send(4'b0000, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 64'hDEAD_BEEF_CAFE_F00D, 0, c1);
    drain();
    out_ready = 0;
    send(4'b1111, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 64'h4, 0, c1);
    repeat (5) tick();
    out_ready = 1;
    drain();
    send(4'b0011, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 64'h5, 1, c1);
    send(4'b1111, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 64'h6, 0, c2);
    chk("back_to_back_accept", c2 - c1, 1);
    drain();
    out_ready = 0;
    send(4'b1111, {32'h73, 32'h72, 32'h71, 32'h70}, 64'h7, 0, c1);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    q.delete();
    tick();
    tick();
    reset = 1;
    out_ready = 1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    rand_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      tm = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom};
      keep = (i < 199) && ($urandom_range(0, 2) == 0);
      send(tm, d, m, keep, c1);
      if (!keep) repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 0;
    out_ready = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
